vend_sequencer: RTL and testbench

Sequencing controller that sits between the coin acceptor, the Mealy vending core, and the physical actuators (product motor, change hopper). It records the core's one-cycle dispense/change pulses as pending jobs and drives each actuator through a req/ack handshake. It gates coins into the core when too many jobs are outstanding, and enters a sticky fault state on actuator timeout.

---
 rtl/vend_sequencer.sv | 152 +++++++++++++++
 tb/tb_vend_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Sequencer between coin acceptor, vending core and actuators: queues vend/change
// pulses as pending jobs, runs each actuator handshake, gates coins, latches timeout faults.
module vend_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_PEND    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] coin_in,
  output logic [1:0] coin_out,
  input  logic       dispense,
  input  logic       chg5,
  output logic       coin_block,
  output logic       vend_req,
  input  logic       vend_ack,
  output logic       chg_req,
  input  logic       chg_ack,
  output logic       fault,
  input  logic       fault_clr,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshake: req is high for the whole request phase and drops once ack is
  // sampled high; the job completes on the first cycle ack is then sampled low.
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VEND     = 3'd1,
    S_VEND_REL = 3'd2,
    S_CHG      = 3'd3,
    S_CHG_REL  = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   vend_pend_q, vend_pend_d;
  logic [PW-1:0]   chg_pend_q, chg_pend_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            coin_block_q, coin_block_d;
  logic            vend_req_q, vend_req_d;
  logic            chg_req_q, chg_req_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;
  logic            vend_done, chg_done, waiting, timed_out;

  always_comb begin
    vend_done = (state_q == S_VEND_REL) && !vend_ack;
    chg_done  = (state_q == S_CHG_REL) && !chg_ack;
    waiting   = (state_q == S_VEND) || (state_q == S_VEND_REL) ||
                (state_q == S_CHG)  || (state_q == S_CHG_REL);
    timed_out = waiting && (tmo_q == TMO_LAST);

    vend_pend_d = vend_pend_q;
    if (dispense && !vend_done && vend_pend_q != PEND_MAX)
      vend_pend_d = vend_pend_q + PW'(1);
    else if (!dispense && vend_done && vend_pend_q != '0)
      vend_pend_d = vend_pend_q - PW'(1);

    chg_pend_d = chg_pend_q;
    if (chg5 && !chg_done && chg_pend_q != PEND_MAX)
      chg_pend_d = chg_pend_q + PW'(1);
    else if (!chg5 && chg_done && chg_pend_q != '0)
      chg_pend_d = chg_pend_q - PW'(1);

    // After a finished job the other actuator gets priority, so neither starves.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (vend_pend_d != '0)     state_d = S_VEND;
        else if (chg_pend_d != '0) state_d = S_CHG;
      end
      S_VEND: begin
        if (vend_ack)       state_d = S_VEND_REL;
        else if (timed_out) state_d = S_FAULT;
      end
      S_VEND_REL: begin
        if (!vend_ack) begin
          if (chg_pend_d != '0)       state_d = S_CHG;
          else if (vend_pend_d != '0) state_d = S_VEND;
          else                        state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_CHG: begin
        if (chg_ack)        state_d = S_CHG_REL;
        else if (timed_out) state_d = S_FAULT;
      end
      S_CHG_REL: begin
        if (!chg_ack) begin
          if (vend_pend_d != '0)     state_d = S_VEND;
          else if (chg_pend_d != '0) state_d = S_CHG;
          else                       state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || !waiting) tmo_d = '0;
    else                                tmo_d = tmo_q + TW'(1);

    coin_block_d = (state_d == S_FAULT) || (vend_pend_d >= PEND_MAX) ||
                   (chg_pend_d >= PEND_MAX);
    vend_req_d   = (state_d == S_VEND);
    chg_req_d    = (state_d == S_CHG);
    fault_d      = (state_d == S_FAULT);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vend_pend_q  <= '0;
      chg_pend_q   <= '0;
      tmo_q        <= '0;
      coin_block_q <= 1'b0;
      vend_req_q   <= 1'b0;
      chg_req_q    <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vend_pend_q  <= vend_pend_d;
      chg_pend_q   <= chg_pend_d;
      tmo_q        <= tmo_d;
      coin_block_q <= coin_block_d;
      vend_req_q   <= vend_req_d;
      chg_req_q    <= chg_req_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
    end
  end

  assign coin_out   = (coin_block_q || coin_in == 2'b11) ? 2'b00 : coin_in;
  assign coin_block = coin_block_q;
  assign vend_req   = vend_req_q;
  assign chg_req    = chg_req_q;
  assign fault      = fault_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: job-level reference model predicts job start order and
// cycle, coin gating and fault; a negedge monitor compares against the DUT.
module tb_vend_sequencer;

  localparam int ACK_TIMEOUT = 16;
  localparam int MAX_PEND    = 3;
  localparam int W           = 18;
  localparam logic [1:0] JV  = 2'd1;
  localparam logic [1:0] JC  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] coin_in, coin_out;
  logic       dispense, chg5, coin_block, vend_req, vend_ack, chg_req, chg_ack;
  logic       fault, fault_clr, busy;
  logic [2:0] dbg_state;

  vend_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .coin_out(coin_out),
    .dispense(dispense), .chg5(chg5), .coin_block(coin_block),
    .vend_req(vend_req), .vend_ack(vend_ack), .chg_req(chg_req), .chg_ack(chg_ack),
    .fault(fault), .fault_clr(fault_clr), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  int vp, cp;
  bit m_busy, m_fault;
  int fault_at = -1;
  bit pva, pca, pvr, pcr;
  bit auto_ack = 1'b0;
  int v_ph, c_ph, v_cnt, c_cnt;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic void push_job(input logic [1:0] t);
    exp_q.push_back({cyc[15:0], t});
  endfunction

  function automatic void pop_cmp(input string name, input logic [1:0] t);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected job start at cycle %0d", name, cyc);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'({cyc[15:0], t}), 32'(e));
    end
  endfunction

  function automatic int clamp(input int v);
    return (v > MAX_PEND) ? MAX_PEND : ((v < 0) ? 0 : v);
  endfunction

  function automatic void model_clear();
    vp = 0; cp = 0; m_busy = 0; m_fault = 0; pva = 0; pca = 0;
    fault_at = -1;
    exp_q.delete();
  endfunction

  // Reference model: pending counts from issued pulses and completed handshakes,
  // and the job that must start next after each completion or from idle.
  always @(posedge clk) begin
    bit vd, cd;
    cyc = cyc + 1;
    if (rst_n) begin
      vd  = pva && !vend_ack;
      cd  = pca && !chg_ack;
      pva = vend_ack;
      pca = chg_ack;
      vp  = clamp(vp + int'(dispense) - int'(vd));
      cp  = clamp(cp + int'(chg5) - int'(cd));
      if (m_fault) begin
        if (fault_clr) begin m_fault = 0; m_busy = 0; end
      end else if (cyc == fault_at) begin
        m_fault = 1;
      end else if (vd) begin
        if (cp > 0)      push_job(JC);
        else if (vp > 0) push_job(JV);
        else             m_busy = 0;
      end else if (cd) begin
        if (vp > 0)      push_job(JV);
        else if (cp > 0) push_job(JC);
        else             m_busy = 0;
      end else if (!m_busy && (vp > 0 || cp > 0)) begin
        push_job((vp > 0) ? JV : JC);
        m_busy = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0] ec;
    bit eb;
    if (rst_n) begin
      eb = m_fault || vp >= MAX_PEND || cp >= MAX_PEND;
      ec = (eb || coin_in == 2'b11) ? 2'b00 : coin_in;
      check("coin_block", 32'(coin_block), 32'(eb));
      check("coin_out", 32'(coin_out), 32'(ec));
      check("fault", 32'(fault), 32'(m_fault));
      check("busy", 32'(busy), 32'(m_busy || m_fault));
      if (vend_req && !pvr) pop_cmp("vend_start", JV);
      if (chg_req && !pcr)  pop_cmp("chg_start", JC);
    end
    pvr = vend_req;
    pcr = chg_req;
  end

  // ---------------- automatic actuator responder ----------------
  always @(posedge clk) begin
    #1;
    if (auto_ack && rst_n) begin
      case (v_ph)
        0: if (vend_req) begin v_cnt = $urandom_range(0, 4); v_ph = 1; end
        1: if (v_cnt == 0) begin vend_ack = 1'b1; v_ph = 2; end else v_cnt--;
        2: if (!vend_req) begin v_cnt = $urandom_range(0, 3); v_ph = 3; end
        default: if (v_cnt == 0) begin vend_ack = 1'b0; v_ph = 0; end else v_cnt--;
      endcase
      case (c_ph)
        0: if (chg_req) begin c_cnt = $urandom_range(0, 4); c_ph = 1; end
        1: if (c_cnt == 0) begin chg_ack = 1'b1; c_ph = 2; end else c_cnt--;
        2: if (!chg_req) begin c_cnt = $urandom_range(0, 3); c_ph = 3; end
        default: if (c_cnt == 0) begin chg_ack = 1'b0; c_ph = 0; end else c_cnt--;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit d, input bit c);
    dispense = d;
    chg5     = c;
    tick();
    dispense = 1'b0;
    chg5     = 1'b0;
  endtask

  task automatic wait_req(input bit is_chg, input bit level);
    int n = 0;
    while (((is_chg ? chg_req : vend_req) != level) && n < 40) begin
      tick();
      n++;
    end
    check(is_chg ? "wait_chg_req" : "wait_vend_req",
          32'(is_chg ? chg_req : vend_req), 32'(level));
  endtask

  task automatic serve(input bit is_chg, input int d_hi, input int d_lo);
    wait_req(is_chg, 1'b1);
    repeat (d_hi) tick();
    if (is_chg) chg_ack = 1'b1; else vend_ack = 1'b1;
    tick();
    wait_req(is_chg, 1'b0);
    repeat (d_lo) tick();
    if (is_chg) chg_ack = 1'b0; else vend_ack = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst_n = 1'b0;
    coin_in = 2'b01; dispense = 0; chg5 = 0; vend_ack = 0; chg_ack = 0; fault_clr = 0;
    v_ph = 0; c_ph = 0; v_cnt = 0; c_cnt = 0;
    model_clear();
    repeat (3) tick();
    check("rst_vend_req", 32'(vend_req), 32'd0);
    check("rst_chg_req", 32'(chg_req), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coin_block", 32'(coin_block), 32'd0);
    check("rst_coin_out", 32'(coin_out), 32'd1);
    rst_n = 1'b1;
    repeat (4) tick();

    // single vend job
    pulse(1, 0);
    check("t1_vend_req_rise", 32'(vend_req), 32'd1);
    serve(0, 1, 1);
    check("t1_busy_low", 32'(busy), 32'd0);
    repeat (3) tick();

    // vend and change together: vend first, change immediately after
    pulse(1, 1);
    serve(0, 2, 2);
    check("t2_chg_follows", 32'(chg_req), 32'd1);
    serve(1, 2, 2);
    repeat (2) tick();
    check("t2_idle", 32'(busy), 32'd0);

    // saturation and coin gating
    coin_in = 2'b01;
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    check("t3_block_set", 32'(coin_block), 32'd1);
    check("t3_coin_gated", 32'(coin_out), 32'd0);
    pulse(1, 0);
    serve(0, 0, 0);
    check("t3_block_clr", 32'(coin_block), 32'd0);
    check("t3_coin_pass", 32'(coin_out), 32'd1);
    serve(0, 1, 1);
    serve(0, 1, 1);
    repeat (3) tick();
    check("t3_saturated_idle", 32'(busy), 32'd0);

    // actuator timeout, fault hold and clear
    fault_at = cyc + 1 + ACK_TIMEOUT;
    pulse(1, 0);
    guard = 0;
    while (cyc < fault_at && guard < 60) begin tick(); guard++; end
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_fault_block", 32'(coin_block), 32'd1);
    check("t4_fault_noreq", 32'(vend_req), 32'd0);
    pulse(0, 1);
    check("t4_fault_nochg", 32'(chg_req), 32'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("t4_fault_dropped", 32'(fault), 32'd0);
    tick();
    check("t4_vend_reassert", 32'(vend_req), 32'd1);
    fault_at = -1;
    serve(0, 1, 1);
    serve(1, 1, 1);
    repeat (3) tick();

    // invalid coin, then async reset during a change handshake
    coin_in = 2'b11;
    tick();
    check("t5_invalid_coin", 32'(coin_out), 32'd0);
    coin_in = 2'b10;
    pulse(0, 1); pulse(0, 1); pulse(0, 1);
    check("t5_chg_req", 32'(chg_req), 32'd1);
    check("t5_chg_block", 32'(coin_block), 32'd1);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("t5_async_chg_req", 32'(chg_req), 32'd0);
    check("t5_async_vend_req", 32'(vend_req), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_block", 32'(coin_block), 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_pend_discarded", 32'(busy), 32'd0);

    // randomized traffic with an automatic responder
    auto_ack = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      dispense  = ($urandom_range(0, 5) == 0);
      chg5      = ($urandom_range(0, 5) == 0);
      coin_in   = 2'($urandom_range(0, 3));
      fault_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    dispense = 0; chg5 = 0; fault_clr = 0;
    guard = 0;
    while ((m_busy || exp_q.size() != 0 || v_ph != 0 || c_ph != 0) && guard < 300) begin
      tick();
      guard++;
    end
    check("rand_drained", 32'(m_busy || v_ph != 0 || c_ph != 0), 32'd0);
    auto_ack = 1'b0;
    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
